// File: rtl/chan_scan_mux_pkg.sv
// mux_pkg: shared types and next-enabled-channel search for chan_scan_mux
// Contents: mode_e, state_e, MAX_CH, next_en()
package mux_pkg;
    typedef enum logic {MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1} mode_e;
    typedef enum logic {ST_RUN, ST_BLANK} state_e;
    localparam int MAX_CH = 32;
    // First enabled channel above cur (wrapping); cur itself when no other is enabled.
    function automatic int unsigned next_en(int unsigned cur, logic [MAX_CH-1:0] mask, int unsigned n);
        int unsigned r, c;
        logic [MAX_CH-1:0] m;
        logic found;
        r = cur;
        found = 1'b0;
        for (int unsigned i = 1; i < MAX_CH; i++) begin
            c = cur + i;
            if (c >= n) c = c - n;
            m = mask >> c;
            if (!found && i < n && m[0]) begin
                r = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/chan_scan_mux_if.sv
// chan_scan_mux_if: channel data, selection controls and mux outputs
// master: drives data_in, sel, mode, ch_enable; slave: drives y, ch_idx, ch_change
interface chan_scan_mux_if
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int SW = $clog2(N_CH);
    logic [N_CH*WIDTH-1:0] data_in;
    logic [SW-1:0]         sel;
    mode_e                 mode;
    logic [N_CH-1:0]       ch_enable;
    logic [WIDTH-1:0]      y;
    logic [SW-1:0]         ch_idx;
    logic                  ch_change;
    modport master(output data_in, sel, mode, ch_enable, input y, ch_idx, ch_change);
    modport slave(input data_in, sel, mode, ch_enable, output y, ch_idx, ch_change);
endinterface

// File: rtl/chan_scan_mux_scan_prescaler.sv
// scan_prescaler: dwell counter 0..SCAN_DIV-1, tick on the terminal count
// Ports: clk, reset, clr (hold at 0), en (count), tick
module scan_prescaler #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(SCAN_DIV);
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(SCAN_DIV - 1);
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: N-channel registered word mux with manual select and timed auto-scan
// Ports: clk, reset (sync, active high), bus (chan_scan_mux_if.slave)
// Optional CHAN_SCAN_MUX_BLANK_EN: zero y for BLANK_CYCLES after each channel change
module chan_scan_mux
    import mux_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int WIDTH        = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    chan_scan_mux_if.slave bus
);
    localparam int SW = $clog2(N_CH);
    logic scan, tick, change, all_off;
    logic [SW-1:0] idx, next_idx;
    logic [WIDTH-1:0] y_r, live;
    logic chg;
    assign scan = bus.mode == MODE_SCAN;
    scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_pre (
        .clk(clk),
        .reset(reset),
        .clr(!scan),
        .en(scan),
        .tick(tick)
    );
    // Out-of-range manual selects keep the current channel.
    always_comb next_idx = scan ? (tick ? SW'(next_en(32'(idx), MAX_CH'(bus.ch_enable), N_CH)) : idx)
                                : (32'(bus.sel) < N_CH ? bus.sel : idx);
    assign all_off = scan && bus.ch_enable == '0;
    assign live    = all_off ? '0 : bus.data_in[next_idx*WIDTH +: WIDTH];
    assign change  = next_idx != idx;
`ifdef CHAN_SCAN_MUX_BLANK_EN
    localparam int BW = $clog2(BLANK_CYCLES) + 1;
    state_e state;
    logic [BW-1:0] bcnt;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
            y_r <= '0;
            chg <= 1'b0;
`ifdef CHAN_SCAN_MUX_BLANK_EN
            state <= ST_RUN;
            bcnt <= '0;
`endif
        end else begin
            idx <= next_idx;
            chg <= change;
`ifdef CHAN_SCAN_MUX_BLANK_EN
            // The change edge itself is the first blanked cycle; a change while blanked reloads.
            if (change) begin
                state <= ST_BLANK;
                bcnt <= BW'(BLANK_CYCLES - 1);
                y_r <= '0;
            end else if (state == ST_BLANK) begin
                if (bcnt == '0) begin
                    state <= ST_RUN;
                    y_r <= live;
                end else begin
                    bcnt <= bcnt - 1'b1;
                    y_r <= '0;
                end
            end else y_r <= live;
`else
            y_r <= live;
`endif
        end
    end
    assign bus.y         = y_r;
    assign bus.ch_idx    = idx;
    assign bus.ch_change = chg;
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: directed table and sequence checks for chan_scan_mux
module tb_chan_scan_mux;
    import mux_pkg::*;
    localparam int N_CH = 4, WIDTH = 8, SCAN_DIV = 4, BLANK_CYCLES = 2;
`ifdef CHAN_SCAN_MUX_BLANK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    chan_scan_mux_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();
    chan_scan_mux #(.N_CH(N_CH), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] chan [4];
    typedef struct {
        logic rst;
        mode_e mode;
        logic [1:0] sel;
        logic [3:0] en;
        logic [7:0] y;
        logic [7:0] yb;
        logic [1:0] idx;
        logic chg;
    } vec_t;
    vec_t vt [10];
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic check_out(input string tag, input logic [7:0] ey, input logic [1:0] ei, input logic ec);
        chk({tag, "_y"}, 32'(bus.y), 32'(ey));
        chk({tag, "_idx"}, 32'(bus.ch_idx), 32'(ei));
        chk({tag, "_chg"}, 32'(bus.ch_change), 32'(ec));
    endtask
    function automatic logic [7:0] yx(input logic [7:0] nb, input logic [7:0] b);
        return BLK ? b : nb;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_data();
        bus.data_in = {chan[3], chan[2], chan[1], chan[0]};
    endtask
    logic [1:0] sq [4];
    initial begin
        chan = '{8'h11, 8'h22, 8'h33, 8'h44};
        sq = '{2'd1, 2'd3, 2'd0, 2'd1};
        set_data();
        bus.sel = 2'd2;
        bus.mode = MODE_MANUAL;
        bus.ch_enable = 4'h0;
        vt[0] = '{1'b1, MODE_MANUAL, 2'd2, 4'h0, 8'h00, 8'h00, 2'd0, 1'b0};
        vt[1] = '{1'b1, MODE_MANUAL, 2'd2, 4'h0, 8'h00, 8'h00, 2'd0, 1'b0};
        vt[2] = '{1'b1, MODE_MANUAL, 2'd2, 4'h0, 8'h00, 8'h00, 2'd0, 1'b0};
        vt[3] = '{1'b0, MODE_MANUAL, 2'd2, 4'h0, 8'h33, 8'h00, 2'd2, 1'b1};
        vt[4] = '{1'b0, MODE_MANUAL, 2'd2, 4'h0, 8'h33, 8'h00, 2'd2, 1'b0};
        vt[5] = '{1'b0, MODE_MANUAL, 2'd2, 4'h0, 8'h33, 8'h33, 2'd2, 1'b0};
        vt[6] = '{1'b0, MODE_MANUAL, 2'd3, 4'h0, 8'h44, 8'h00, 2'd3, 1'b1};
        vt[7] = '{1'b0, MODE_MANUAL, 2'd0, 4'hf, 8'h11, 8'h00, 2'd0, 1'b1};
        vt[8] = '{1'b0, MODE_MANUAL, 2'd0, 4'hf, 8'h11, 8'h00, 2'd0, 1'b0};
        vt[9] = '{1'b0, MODE_MANUAL, 2'd0, 4'hf, 8'h11, 8'h11, 2'd0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            reset = vt[i].rst;
            bus.mode = vt[i].mode;
            bus.sel = vt[i].sel;
            bus.ch_enable = vt[i].en;
            step();
            check_out($sformatf("vec%0d", i), yx(vt[i].y, vt[i].yb), vt[i].idx, vt[i].chg);
        end
        chan[0] = 8'h55;
        set_data();
        step();
        check_out("data_lat", 8'h55, 2'd0, 1'b0);
        chan[0] = 8'h11;
        set_data();
        step();
        check_out("data_back", 8'h11, 2'd0, 1'b0);
        bus.sel = 2'd1;
        step();
        check_out("bl_a0", yx(8'h22, 8'h00), 2'd1, 1'b1);
        bus.sel = 2'd2;
        step();
        check_out("bl_a1", yx(8'h33, 8'h00), 2'd2, 1'b1);
        step();
        check_out("bl_a2", yx(8'h33, 8'h00), 2'd2, 1'b0);
        step();
        check_out("bl_a3", 8'h33, 2'd2, 1'b0);
        bus.sel = 2'd0;
        step();
        check_out("bl_b0", yx(8'h11, 8'h00), 2'd0, 1'b1);
        step();
        check_out("bl_b1", yx(8'h11, 8'h00), 2'd0, 1'b0);
        step();
        check_out("bl_b2", 8'h11, 2'd0, 1'b0);
        bus.mode = MODE_SCAN;
        bus.ch_enable = 4'b1011;
        for (int k = 0; k < 16; k++) begin
            automatic int ph = k % 4;
            automatic logic [1:0] ei = (ph == 3) ? sq[k/4] : (k < 4 ? 2'd0 : sq[k/4-1]);
            automatic logic bz = ph == 3 || (ph == 0 && k > 0);
            step();
            check_out($sformatf("scan%0d", k), yx(chan[ei], bz ? 8'h00 : chan[ei]), ei, ph == 3);
        end
        bus.ch_enable = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            step();
            check_out($sformatf("none%0d", k), 8'h00, 2'd1, 1'b0);
        end
        bus.mode = MODE_MANUAL;
        bus.sel = 2'd0;
        step();
        check_out("back0", yx(8'h11, 8'h00), 2'd0, 1'b1);
        step();
        check_out("back1", yx(8'h11, 8'h00), 2'd0, 1'b0);
        step();
        check_out("back2", 8'h11, 2'd0, 1'b0);
        bus.mode = MODE_SCAN;
        bus.ch_enable = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            step();
            check_out($sformatf("only%0d", k), 8'h11, 2'd0, 1'b0);
        end
        bus.mode = MODE_MANUAL;
        bus.sel = 2'd1;
        step();
        check_out("pre0", yx(8'h22, 8'h00), 2'd1, 1'b1);
        step();
        step();
        check_out("pre2", 8'h22, 2'd1, 1'b0);
        bus.mode = MODE_SCAN;
        bus.ch_enable = 4'b1011;
        step();
        step();
        check_out("mid", 8'h22, 2'd1, 1'b0);
        reset = 1'b1;
        step();
        check_out("rst_mid", 8'h00, 2'd0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("dwell%0d", k), 8'h11, 2'd0, 1'b0);
        end
        step();
        check_out("dwell3", yx(8'h22, 8'h00), 2'd1, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/chan_scan_mux.md
# chan_scan_mux

Parametrised N-channel, W-bit registered multiplexer with manual and auto-scan selection. Generalises the 2:1 bit mux to N_CH word-wide channels with a registered output. Adds a timed scan mode that rotates through an enable mask, and a channel-change strobe. Sits between the data sources and time-shared display/output drivers.

## Interface
- N_CH, 4, number of input channels (≥2)
- WIDTH, 8, bits per channel
- SCAN_DIV, 100000, clocks per channel dwell in scan mode (≥2)
- BLANK_CYCLES, 2, output-blank length after a channel change (≥1; used only with blanking compiled in)

- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- data_in  in  N_CH*WIDTH  packed channels; channel i = data_in[i*WIDTH +: WIDTH]
- sel  in  $clog2(N_CH)  manual channel select
- mode  in  1  0 = manual, 1 = scan
- ch_enable  in  N_CH  scan-mode channel mask (bit i enables channel i)
- y  out  WIDTH  registered selected data
- ch_idx  out  $clog2(N_CH)  currently selected channel
- ch_change  out  1  one-cycle pulse on the cycle ch_idx takes a new value

## Operation
- next_idx is computed combinationally. On each edge: ch_idx <= next_idx and y <= channel[next_idx], unless blanked.
- Manual mode: next_idx = sel when sel < N_CH; sel ≥ N_CH is ignored and next_idx = ch_idx. ch_enable is ignored.
- Scan mode:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - At terminal count, next_idx = the first enabled channel after ch_idx, searching upward with wrap N_CH-1 → 0.
- Scan-mode boundary cases:
  - Only the current channel enabled: no change and no pulse.
  - ch_enable all zero: ch_idx holds, y forced to 0, no pulse.
  - Current channel disabled mid-dwell: it stays selected until the next terminal count.
- Mode 0→1: prescaler cleared to 0 on the first scan cycle; scanning starts from the current ch_idx.
- Mode 1→0: next_idx = sel on the first manual cycle; prescaler held at 0.
- ch_change = 1 exactly when next_idx ≠ ch_idx at the edge.
- FSM:
  - ST_RUN → ST_BLANK on a channel change (blanking compiled in).
  - ST_BLANK → ST_RUN after BLANK_CYCLES cycles.
  - A change during ST_BLANK reloads the blank counter.
  - Without blanking, the FSM stays in ST_RUN.

## Timing
- Reset values: y = 0, ch_idx = 0, ch_change = 0, prescaler = 0, state ST_RUN, blank counter 0.
- Reset asserted mid-dwell or mid-blank aborts immediately at the next edge.
- Latency: sel or data_in change before edge k is visible on y and ch_idx after edge k (1 cycle).
- Scan dwell is exactly SCAN_DIV cycles per channel; ch_change is high for 1 cycle per step.
- Blanking: y = 0 for the BLANK_CYCLES cycles starting with the edge that updates ch_idx; y shows live data on the following edge. The prescaler keeps running during blank.

## Configuration
- CHAN_SCAN_MUX_BLANK_EN defined: blanking FSM and counter present; y is zeroed for BLANK_CYCLES after each channel change.
- Not defined: no blank logic; y always follows channel[next_idx] with 1-cycle latency; BLANK_CYCLES unused.

## Structure
- Package mux_pkg:
  - mode_e (MODE_MANUAL = 0, MODE_SCAN = 1)
  - state_e (ST_RUN, ST_BLANK)
  - helper function that returns the next enabled index given the current index and mask
- Sub-module scan_prescaler: counter with inputs clr and en, output tick at SCAN_DIV-1; instantiated once.

## Test plan
Bench configuration: N_CH = 4, WIDTH = 8, SCAN_DIV = 4, BLANK_CYCLES = 2; channels = 8'h11, 8'h22, 8'h33, 8'h44.
- Reset held for 3 cycles, then mode = 0, sel = 2 → y = 0 during reset; y = 8'h33, ch_idx = 2, ch_change = 1 for 1 cycle.
- Manual: sel = 3 then sel = 0 on consecutive cycles → y = 8'h44 then 8'h11, one ch_change pulse each.
- Scan with ch_enable = 4'b1011 from ch_idx = 0 → ch_idx sequence 0, 1, 3, 0, each held exactly 4 cycles (channel 2 skipped).
- Scan with ch_enable = 4'b0000 → y = 0, ch_idx holds, no ch_change; with ch_enable = 4'b0001 at ch_idx = 0 → no pulses.
- Blanking compiled in, manual sel 0 → 1 → y = 0, 0, then 8'h22. A second change to sel = 2 during blank gives 2 further zero cycles, then 8'h33.
- Assert reset mid-scan at dwell count 2 → next edge: ch_idx = 0, y = 0, prescaler = 0; after release the dwell restarts with a full 4 cycles.
